wb_flash_prefetch: RTL

//  Single-line read prefetch buffer between the CPU instruction/data Wishbone bus and the G18 flash slave.
//  On a miss it fetches the whole aligned line as back-to-back classic reads, then serves hits with 1-cycle latency.

---
 rtl/wb_flash_prefetch.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/wb_flash_prefetch.sv
// Single-line read prefetch buffer in front of the G18 flash slave.
// A miss fetches the whole aligned line as back-to-back classic reads; hits
// are answered one cycle after the request. Writes are answered with an error.
//
// Handshake: a slave request is wbs_cyc_i & wbs_stb_i while neither
// wbs_ack_o nor wbs_err_o is high; it is answered by exactly one single-cycle
// wbs_ack_o or wbs_err_o, unless the master drops wbs_cyc_i during a line fill,
// in which case no answer is given. On the master side each word is a
// separate classic cycle: cyc/stb rise, stay high until wbm_ack_i or
// wbm_err_i, then drop for one cycle before the next word.
module wb_flash_prefetch #(
  parameter int wb_aw      = 32,
  parameter int LINE_WORDS = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [wb_aw-1:0] wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic             wbs_we_i,
  input  logic [2:0]       wbs_cti_i,
  input  logic [1:0]       wbs_bte_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  output logic             wbs_ack_o,
  output logic             wbs_err_o,
  output logic [31:0]      wbs_dat_o,
  output logic [wb_aw-1:0] wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_we_o,
  output logic [2:0]       wbm_cti_o,
  output logic [1:0]       wbm_bte_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i,
  input  logic [31:0]      wbm_dat_i,
  input  logic             invalidate_i
);

  localparam int LW = $clog2(LINE_WORDS);
  localparam int TW = wb_aw - LW - 2;

  typedef enum logic [1:0] {IDLE, FILL, RESP, ERR} state_t;

  // state is kept as a plain named signal so checkers can bind to it
  state_t          state, state_nxt;
  logic [31:0]     line_q [LINE_WORDS];
  logic [TW-1:0]   tag_q;
  logic [TW-1:0]   base_tag_q;
  logic [LW-1:0]   cnt_q;
  logic [LW-1:0]   word_idx_q;
  logic            valid_q;
  logic            inv_pend_q;
  logic            abort_q;
  logic            gap_q;

  logic            req;
  logic            hit;
  logic            last_word;
  logic [TW-1:0]   adr_tag;
  logic [LW-1:0]   adr_word;
  logic            unused_ok;

  assign adr_tag   = wbs_adr_i[wb_aw-1:LW+2];
  assign adr_word  = wbs_adr_i[LW+1:2];
  assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
  assign hit       = valid_q & (tag_q == adr_tag);
  assign last_word = (cnt_q == LW'(LINE_WORDS - 1));

  // Responses depend only on registered state, so nothing is combinational
  // from the slave inputs to the slave outputs.
  assign wbs_ack_o = (state == RESP) & ~abort_q;
  assign wbs_err_o = (state == ERR) & ~abort_q;
  assign wbs_dat_o = wbs_ack_o ? line_q[word_idx_q] : 32'h0;

  // Master port: read-only classic cycles, one dead cycle after each ack.
  assign wbm_cyc_o = (state == FILL) & ~gap_q;
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_adr_o = {base_tag_q, cnt_q, 2'b00};
  assign wbm_dat_o = 32'h0;
  assign wbm_sel_o = 4'hf;
  assign wbm_we_o  = 1'b0;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;

  // Inputs that carry no meaning for a read-only word-wide buffer.
  assign unused_ok = ^{wbs_dat_i, wbs_sel_i, wbs_cti_i, wbs_bte_i, wbs_adr_i[1:0]};

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (wbs_we_i)  state_nxt = ERR;
          else if (hit)  state_nxt = RESP;
          else           state_nxt = FILL;
        end
      end
      FILL: begin
        if (!gap_q) begin
          if (wbm_err_i)                  state_nxt = ERR;
          else if (wbm_ack_i && last_word) state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Line storage, tag/valid tracking and fill bookkeeping.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < LINE_WORDS; i++) line_q[i] <= 32'h0;
      tag_q      <= '0;
      base_tag_q <= '0;
      cnt_q      <= '0;
      word_idx_q <= '0;
      valid_q    <= 1'b0;
      inv_pend_q <= 1'b0;
      abort_q    <= 1'b0;
      gap_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (invalidate_i) valid_q <= 1'b0;
          if (req) abort_q <= 1'b0;
          if (req && !wbs_we_i) begin
            word_idx_q <= adr_word;
            if (!hit) begin
              // The old line is being overwritten, so it can no longer hit.
              base_tag_q <= adr_tag;
              cnt_q      <= '0;
              gap_q      <= 1'b0;
              inv_pend_q <= 1'b0;
              valid_q    <= 1'b0;
            end
          end
        end
        FILL: begin
          if (!wbs_cyc_i)   abort_q    <= 1'b1;
          if (invalidate_i) inv_pend_q <= 1'b1;
          if (gap_q) begin
            gap_q <= 1'b0;
          end else if (wbm_err_i) begin
            valid_q    <= 1'b0;
            inv_pend_q <= 1'b0;
          end else if (wbm_ack_i) begin
            line_q[cnt_q] <= wbm_dat_i;
            if (last_word) begin
              tag_q      <= base_tag_q;
              valid_q    <= ~(inv_pend_q | invalidate_i);
              inv_pend_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + LW'(1);
              gap_q <= 1'b1;
            end
          end
        end
        default: begin
          if (invalidate_i) valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
